// File: rtl/shift_interp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_interp_pkg
// Brief    : Shared widths, types and saturation limits for shift_interp_datapath
// Revision : 1.0 - initial release
// ============================================================================
package shift_interp_pkg;

  localparam int DATA_W = 16;
  localparam int SHW    = 6;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic        [SHW-1:0]    shamt_t;
  typedef logic signed [DATA_W+1:0] psum_t;

  localparam sample_t SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam sample_t SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

endpackage : shift_interp_pkg
`default_nettype wire

// File: rtl/shift_interp_datapath_term.sv
`default_nettype none
// ============================================================================
// Module   : shift_term
// Brief    : One tap term p >>> s with zero clamp for s >= DATA_W.
//            Round-half-up when SHIFT_INTERP_ROUND_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module shift_term #(
  parameter int DATA_W = shift_interp_pkg::DATA_W,
  parameter int SHW    = shift_interp_pkg::SHW
) (
  input  logic signed [DATA_W-1:0] p_i,
  input  logic        [SHW-1:0]    s_i,
  output logic signed [DATA_W-1:0] t_o
);

  import shift_interp_pkg::*;

`ifdef SHIFT_INTERP_ROUND_EN
  logic signed [DATA_W:0] w_one;
  logic signed [DATA_W:0] w_ext;
  logic signed [DATA_W:0] w_sh;

  always_comb begin
    t_o   = '0;
    w_one = {{DATA_W{1'b0}}, 1'b1};
    w_ext = '0;
    w_sh  = '0;
    if (int'(s_i) >= DATA_W) begin
      t_o = '0;
    end else if (s_i == '0) begin
      t_o = p_i;
    end else begin
      // One extra bit keeps p + 2^(s-1) from wrapping near SAT_MAX.
      w_ext = {p_i[DATA_W-1], p_i} + (w_one << (s_i - 1'b1));
      w_sh  = w_ext >>> s_i;
      t_o   = w_sh[DATA_W-1:0];
    end
  end
`else
  always_comb begin
    t_o = '0;
    if (int'(s_i) < DATA_W) begin
      t_o = p_i >>> s_i;
    end
  end
`endif

endmodule : shift_term
`default_nettype wire

// File: rtl/shift_interp_datapath.sv
`default_nettype none
// ============================================================================
// Module   : shift_interp_datapath
// Brief    : 3-stage multiplier-free bilinear interpolator (sum of p_i >>> s_i),
//            saturating, valid/ready both sides. Option: SHIFT_INTERP_ROUND_EN.
// Revision : 1.0 - initial release
// ============================================================================
module shift_interp_datapath #(
  parameter int DATA_W = shift_interp_pkg::DATA_W,
  parameter int SHW    = shift_interp_pkg::SHW,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] p0,
  input  logic signed [DATA_W-1:0] p1,
  input  logic signed [DATA_W-1:0] p2,
  input  logic signed [DATA_W-1:0] p3,
  input  logic        [SHW-1:0]    s0,
  input  logic        [SHW-1:0]    s1,
  input  logic        [SHW-1:0]    s2,
  input  logic        [SHW-1:0]    s3,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_sat,
  output logic        [CNT_W-1:0]  sat_cnt,
  input  logic                     sat_clr
);

  import shift_interp_pkg::*;

  localparam logic signed [DATA_W+1:0] C_PMAX = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W+1:0] C_PMIN = {3'b111, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] C_OMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] C_OMIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] w_p [4];
  logic        [SHW-1:0]    w_s [4];
  logic signed [DATA_W-1:0] w_t [4];

  logic                     v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [DATA_W-1:0] t_q [4];
  logic signed [DATA_W:0]   a_q, a_d, b_q, b_d;
  logic signed [DATA_W-1:0] data_q, data_d;
  logic                     sat_q, sat_d;
  logic        [CNT_W-1:0]  cnt_q, cnt_d;
  logic signed [DATA_W+1:0] w_sum;
  logic                     w_ld1, w_ld2, w_ld3, w_out_xfer;

  assign w_p[0] = p0;
  assign w_p[1] = p1;
  assign w_p[2] = p2;
  assign w_p[3] = p3;
  assign w_s[0] = s0;
  assign w_s[1] = s1;
  assign w_s[2] = s2;
  assign w_s[3] = s3;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_term
      shift_term #(
        .DATA_W (DATA_W),
        .SHW    (SHW)
      ) u_term (
        .p_i (w_p[gi]),
        .s_i (w_s[gi]),
        .t_o (w_t[gi])
      );
    end
  endgenerate

  // Each stage loads when empty or when the stage after it loads; bubbles collapse.
  assign w_ld3      = !v3_q | out_ready;
  assign w_ld2      = !v2_q | w_ld3;
  assign w_ld1      = !v1_q | w_ld2;
  assign in_ready   = w_ld1;
  assign w_out_xfer = v3_q & out_ready;

  always_comb begin
    v1_d   = w_ld1 ? in_valid : v1_q;
    v2_d   = w_ld2 ? v1_q : v2_q;
    v3_d   = w_ld3 ? v2_q : v3_q;
    a_d    = {t_q[0][DATA_W-1], t_q[0]} + {t_q[1][DATA_W-1], t_q[1]};
    b_d    = {t_q[2][DATA_W-1], t_q[2]} + {t_q[3][DATA_W-1], t_q[3]};
    w_sum  = {a_q[DATA_W], a_q} + {b_q[DATA_W], b_q};
    data_d = w_sum[DATA_W-1:0];
    sat_d  = 1'b0;
    if (w_sum > C_PMAX) begin
      data_d = C_OMAX;
      sat_d  = 1'b1;
    end else if (w_sum < C_PMIN) begin
      data_d = C_OMIN;
      sat_d  = 1'b1;
    end
    cnt_d = cnt_q;
    if (sat_clr) begin
      cnt_d = '0;
    end else if (w_out_xfer && sat_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      for (int i = 0; i < 4; i++) t_q[i] <= '0;
      a_q    <= '0;
      b_q    <= '0;
      data_q <= '0;
      sat_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      cnt_q <= cnt_d;
      if (w_ld1 && in_valid) begin
        for (int i = 0; i < 4; i++) t_q[i] <= w_t[i];
      end
      if (w_ld2 && v1_q) begin
        a_q <= a_d;
        b_q <= b_d;
      end
      if (w_ld3 && v2_q) begin
        data_q <= data_d;
        sat_q  <= sat_d;
      end
    end
  end

  assign out_valid = v3_q;
  assign out_data  = data_q;
  assign out_sat   = sat_q;
  assign sat_cnt   = cnt_q;

endmodule : shift_interp_datapath
`default_nettype wire
